// File: rtl/ram_fifo_ctrl.sv
// Circular-queue controller that runs one external 1R1W RAM (async read, sync write) as a FIFO.
// Holds the head/tail pointers, occupancy count and EMPTY/PARTIAL/FULL state; the storage lives outside.
module ram_fifo_ctrl #(
    parameter int DEPTH     = 64,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 32,
    parameter int AF_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic             pop_valid_o,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [INDEX:0]   count_o,
    output logic             almost_full_o,
    output logic [INDEX-1:0] ram_addr0_o,
    input  logic [WIDTH-1:0] ram_data0_i,
    output logic             ram_we_o,
    output logic [INDEX-1:0] ram_addrWr_o,
    output logic [WIDTH-1:0] ram_data_o
);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

    localparam logic [INDEX:0] DEPTH_C = (INDEX+1)'(DEPTH);
    localparam logic [INDEX:0] AF_C    = (INDEX+1)'(AF_THRESH);

    state_e           state_q, state_d;
    logic [INDEX-1:0] head_q, head_d;
    logic [INDEX-1:0] tail_q, tail_d;
    logic [INDEX:0]   count_q, count_d;
    logic             push_fire;
    logic             pop_fire;

    // A pop while FULL frees the head slot in the same cycle, so a push may reuse it.
    assign push_ready_o  = (state_q != FULL) | pop_i;
    assign pop_valid_o   = (state_q != EMPTY);
    assign push_fire     = push_i & push_ready_o & ~flush_i & ~reset;
    assign pop_fire      = pop_i & pop_valid_o & ~flush_i;

    assign pop_data_o    = ram_data0_i;
    assign count_o       = count_q;
    assign almost_full_o = (DEPTH_C - count_q) <= AF_C;
    assign ram_addr0_o   = head_q;
    assign ram_we_o      = push_fire;
    assign ram_addrWr_o  = tail_q;
    assign ram_data_o    = push_data_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (push_fire) tail_d = tail_q + INDEX'(1);
        if (pop_fire)  head_d = head_q + INDEX'(1);
        if (push_fire && !pop_fire)      count_d = count_q + (INDEX+1)'(1);
        else if (pop_fire && !push_fire) count_d = count_q - (INDEX+1)'(1);
        if (count_d == '0)          state_d = EMPTY;
        else if (count_d == DEPTH_C) state_d = FULL;
        else                         state_d = PARTIAL;
        // Flush outranks any push/pop issued in the same cycle.
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= EMPTY;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural 64x32 RAM, a directed vector table,
// and hand-written sequences for fill, full push+pop, wrap streaming and flush.
module tb_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i, push_i, pop_i;
    logic [31:0] push_data_i;
    logic        push_ready_o, pop_valid_o, almost_full_o, ram_we_o;
    logic [31:0] pop_data_o, ram_data0_i, ram_data_o;
    logic [6:0]  count_o;
    logic [5:0]  ram_addr0_o, ram_addrWr_o;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    ram_fifo_ctrl #(.DEPTH(64), .INDEX(6), .WIDTH(32), .AF_THRESH(4)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .push_i(push_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
        .pop_i(pop_i), .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o),
        .count_o(count_o), .almost_full_o(almost_full_o),
        .ram_addr0_o(ram_addr0_o), .ram_data0_i(ram_data0_i),
        .ram_we_o(ram_we_o), .ram_addrWr_o(ram_addrWr_o), .ram_data_o(ram_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we_o) mem[ram_addrWr_o] <= ram_data_o;
    assign ram_data0_i = mem[ram_addr0_o];

    typedef struct {
        logic        push, pop, flush;
        logic [31:0] data;
        logic [6:0]  cnt;
        logic        valid, ready, we;
        logic [5:0]  wa, ra;
        logic        chkd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then wait for the falling edge to sample.
    task automatic applyStimulus(input logic push, input logic pop, input logic flush, input logic [31:0] data);
        push_i      = push;
        pop_i       = pop;
        flush_i     = flush;
        push_data_i = data;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int i, input vec_t v);
        chk($sformatf("v%0d.count", i), 32'(count_o), 32'(v.cnt));
        chk($sformatf("v%0d.valid", i), 32'(pop_valid_o), 32'(v.valid));
        chk($sformatf("v%0d.ready", i), 32'(push_ready_o), 32'(v.ready));
        chk($sformatf("v%0d.we", i), 32'(ram_we_o), 32'(v.we));
        chk($sformatf("v%0d.addrWr", i), 32'(ram_addrWr_o), 32'(v.wa));
        chk($sformatf("v%0d.addr0", i), 32'(ram_addr0_o), 32'(v.ra));
        if (v.chkd) chk($sformatf("v%0d.popData", i), pop_data_o, v.rd);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_DEAD);
        chk("reset.we", 32'(ram_we_o), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset.count", 32'(count_o), 32'd0);
        chk("reset.valid", 32'(pop_valid_o), 32'd0);
        chk("reset.ready", 32'(push_ready_o), 32'd1);
        chk("reset.af", 32'(almost_full_o), 32'd0);
        chk("reset.addr0", 32'(ram_addr0_o), 32'd0);
        chk("reset.addrWr", 32'(ram_addrWr_o), 32'd0);
        tick();
    endtask

    initial begin
        logic [5:0] eh, et;
        int nPush, nPop;
        logic doPush, doPop;

        //          push  pop   flush data          cnt   valid ready we    wa     ra     chkd  rd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'hA0, 7'd0, 1'b0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'hA1, 7'd1, 1'b1, 1'b1, 1'b1, 6'd1, 6'd0, 1'b1, 32'hA0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'hA2, 7'd2, 1'b1, 1'b1, 1'b1, 6'd2, 6'd0, 1'b1, 32'hA0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'hA3, 7'd3, 1'b1, 1'b1, 1'b1, 6'd3, 6'd0, 1'b1, 32'hA0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h00, 7'd4, 1'b1, 1'b1, 1'b0, 6'd4, 6'd0, 1'b1, 32'hA0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00, 7'd3, 1'b1, 1'b1, 1'b0, 6'd4, 6'd1, 1'b1, 32'hA1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h00, 7'd2, 1'b1, 1'b1, 1'b0, 6'd4, 6'd2, 1'b1, 32'hA2};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 7'd1, 1'b1, 1'b1, 1'b0, 6'd4, 6'd3, 1'b1, 32'hA3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 7'd0, 1'b0, 1'b1, 1'b0, 6'd4, 6'd4, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 7'd0, 1'b0, 1'b1, 1'b0, 6'd4, 6'd4, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 7'd0, 1'b0, 1'b1, 1'b0, 6'd4, 6'd4, 1'b0, 32'h0};

        reset = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_data_i = '0;
        #1;
        doReset();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].data);
            checkOutput(i, vecs[i]);
            tick();
        end

        // Fill from head=tail=4 up to 64 entries.
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h100 + 32'(k));
            chk($sformatf("fill%0d.count", k), 32'(count_o), 32'(k));
            chk($sformatf("fill%0d.af", k), 32'(almost_full_o), (k >= 60) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d.we", k), 32'(ram_we_o), 32'd1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        chk("full.count", 32'(count_o), 32'd64);
        chk("full.ready", 32'(push_ready_o), 32'd0);
        chk("full.af", 32'(almost_full_o), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_DEAD);
        chk("fullPush.we", 32'(ram_we_o), 32'd0);
        chk("fullPush.ready", 32'(push_ready_o), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_BEEF);
        chk("fullPushPop.prevCount", 32'(count_o), 32'd64);
        chk("fullPushPop.ready", 32'(push_ready_o), 32'd1);
        chk("fullPushPop.we", 32'(ram_we_o), 32'd1);
        chk("fullPushPop.addrWr", 32'(ram_addrWr_o), 32'd4);
        chk("fullPushPop.addr0", 32'(ram_addr0_o), 32'd4);
        chk("fullPushPop.popData", pop_data_o, 32'h100);
        tick();
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            chk($sformatf("drain%0d.count", k), 32'(count_o), 32'(64 - k));
            chk($sformatf("drain%0d.data", k), pop_data_o, (k < 63) ? 32'h101 + 32'(k) : 32'h0000_BEEF);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        chk("drained.count", 32'(count_o), 32'd0);
        chk("drained.valid", 32'(pop_valid_o), 32'd0);
        tick();

        // Stream 200 entries with occupancy held at 3 so both pointers wrap repeatedly.
        doReset();
        eh = '0; et = '0; nPush = 0; nPop = 0;
        while (nPop < 200) begin
            doPush = (nPush < 200);
            doPop  = ((nPush - nPop) >= 3) || (nPush == 200);
            applyStimulus(doPush, doPop, 1'b0, 32'h2000 + 32'(nPush));
            chk($sformatf("wrap%0d.addr0", nPop), 32'(ram_addr0_o), 32'(eh));
            if (doPush) chk($sformatf("wrap%0d.addrWr", nPush), 32'(ram_addrWr_o), 32'(et));
            if (doPop)  chk($sformatf("wrap%0d.data", nPop), pop_data_o, 32'h2000 + 32'(nPop));
            if (doPush && doPop) chk($sformatf("wrap%0d.count", nPop), 32'(count_o), 32'd3);
            tick();
            if (doPush) begin nPush++; et = et + 6'd1; end
            if (doPop)  begin nPop++;  eh = eh + 6'd1; end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrapEnd.count", 32'(count_o), 32'd0);
        chk("wrapEnd.addr0", 32'(ram_addr0_o), 32'd8);
        tick();

        // Flush with ten entries while push and pop are both requested.
        doReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h300 + 32'(k));
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3FF);
        chk("flush.prevCount", 32'(count_o), 32'd10);
        chk("flush.we", 32'(ram_we_o), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0777);
        chk("flushed.count", 32'(count_o), 32'd0);
        chk("flushed.valid", 32'(pop_valid_o), 32'd0);
        chk("flushed.addr0", 32'(ram_addr0_o), 32'd0);
        chk("flushed.addrWr", 32'(ram_addrWr_o), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        chk("afterFlush.data", pop_data_o, 32'h0000_0777);
        chk("afterFlush.count", 32'(count_o), 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
